// File: rtl/uart_rx_if.sv
// picorv32 native memory bus slice seen by the UART receiver peripheral.
interface uart_rx_if;
  logic        enable;
  logic        mem_valid;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  wire         mem_ready;
  wire  [31:0] mem_rdata;

  modport master (
    output enable,
    output mem_valid,
    output mem_instr,
    output mem_wstrb,
    output mem_wdata,
    output mem_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  enable,
    input  mem_valid,
    input  mem_instr,
    input  mem_wstrb,
    input  mem_wdata,
    input  mem_addr,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver with an 8-entry receive FIFO.
// DATA register at addr[2]=0 (read pops), STATUS at addr[2]=1 (write clears error flags).
module uart_rx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     serialIn,
  uart_rx_if.slave bus
);

  localparam int unsigned DIV     = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W   = $clog2(DIV);
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned PTR_W   = 3;
  localparam int unsigned COUNT_W = 4;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  logic sync1_q;
  logic rx_s;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= serialIn;
      rx_s    <= sync1_q;
    end
  end

  // Receive FSM state
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                push_c;
  logic                frame_err_c;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // Half-bit wait after the falling edge puts every later sample mid-bit
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    push_c      = 1'b0;
    frame_err_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_d   = CNT_W'(DIV / 2 - 1);
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!rx_s) begin
          cnt_d   = CNT_W'(DIV - 1);
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shreg_d = {rx_s, shreg_q[DATA_W-1:1]};
          cnt_d   = CNT_W'(DIV - 1);
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rx_s) begin
          push_c  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          frame_err_c = 1'b1;
          state_d     = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus decode; a request is accepted once, on the cycle before ready
  logic               ready_q;
  logic [31:0]        rdata_q;
  logic [31:0]        rdata_c;
  logic               sel_c;
  logic               accept_c;
  logic               is_status_c;
  logic               is_write_c;
  logic               pop_c;
  logic               clear_c;

  logic [DATA_W-1:0]  fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [COUNT_W-1:0] count_q;
  logic               full_c;
  logic               rx_valid_c;
  logic               push_ok_c;
  logic               overrun_set_c;
  logic               overrun_q;
  logic               framing_q;

  assign sel_c         = bus.mem_valid && bus.enable;
  assign accept_c      = sel_c && !ready_q;
  assign is_status_c   = bus.mem_addr[2];
  assign is_write_c    = |bus.mem_wstrb;
  assign full_c        = (count_q == COUNT_W'(DEPTH));
  assign rx_valid_c    = (count_q != '0);
  assign pop_c         = accept_c && !is_status_c && !is_write_c && rx_valid_c;
  assign clear_c       = accept_c && is_status_c && is_write_c;
  assign push_ok_c     = push_c && !full_c;
  assign overrun_set_c = push_c && full_c;

  // FIFO storage needs no reset; only locations below count are ever read
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      fifo_mem[wr_ptr_q] <= shreg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok_c, pop_c})
        2'b10:   count_q <= count_q + COUNT_W'(1);
        2'b01:   count_q <= count_q - COUNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Error flags are sticky; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun_q <= 1'b0;
      framing_q <= 1'b0;
    end else begin
      if (overrun_set_c) begin
        overrun_q <= 1'b1;
      end else if (clear_c) begin
        overrun_q <= 1'b0;
      end
      if (frame_err_c) begin
        framing_q <= 1'b1;
      end else if (clear_c) begin
        framing_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    if (!is_write_c) begin
      if (is_status_c) begin
        rdata_c = {28'h0, full_c, framing_q, overrun_q, rx_valid_c};
      end else if (rx_valid_c) begin
        rdata_c = {24'h0, fifo_mem[rd_ptr_q]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= accept_c;
      if (accept_c) begin
        rdata_q <= rdata_c;
      end
    end
  end

  // Shared bus: release both return lines whenever this peripheral is not selected
  assign bus.mem_ready = sel_c ? ready_q : 1'bz;
  assign bus.mem_rdata = sel_c ? rdata_q : {32{1'bz}};

  logic unused_ok;
  assign unused_ok = ^{bus.mem_instr, bus.mem_wdata, bus.mem_addr[31:3], bus.mem_addr[1:0]};

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames in, bus reads checked against a queue model.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 1000000;
  localparam int unsigned BAUD     = 100000;
  localparam int unsigned DIV      = CLK_FREQ / BAUD;
  localparam logic [31:0] A_DATA   = 32'h0000_0000;
  localparam logic [31:0] A_STAT   = 32'h0000_0004;

  logic clk = 1'b0;
  logic resetn;
  logic serial_in;

  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .serialIn (serial_in),
    .bus      (bus)
  );

  // Model: bytes the receiver must hold, plus the two sticky error flags
  logic [7:0]  model_q[$];
  logic        model_ovr;
  logic        model_frm;

  int          checks;
  int          failures;
  logic        exp_chk;
  logic [31:0] exp_rdata;
  string       exp_name;

  function automatic logic [31:0] model_status();
    return {28'h0, model_q.size() == 8, model_frm, model_ovr, model_q.size() != 0};
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (model_q.size() == 8) model_ovr = 1'b1;
    else model_q.push_back(b);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Every read's ready cycle is compared against what the model predicted at issue time
  always @(negedge clk) begin
    if (exp_chk && bus.mem_ready === 1'b1) begin
      check(exp_name, bus.mem_rdata, exp_rdata);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    serial_in = v;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  // stop_low > 0 holds the stop bit low that many cycles before releasing it
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (stop_low > 0) begin
      serial_in = 1'b0;
      repeat (stop_low) @(posedge clk);
      #1;
    end
    drive_bit(1'b1);
    if (stop_low == 0) model_push(b);
    else model_frm = 1'b1;
  endtask

  task automatic bus_xfer(input string name, input logic [31:0] addr, input logic [3:0] wstrb,
                          output logic [31:0] rd);
    int n;
    exp_name = name;
    if (wstrb == 4'h0) begin
      if (addr[2]) exp_rdata = model_status();
      else if (model_q.size() != 0) exp_rdata = {24'h0, model_q.pop_front()};
      else exp_rdata = 32'h0;
      exp_chk = 1'b1;
    end else begin
      exp_chk = 1'b0;
      if (addr[2]) begin
        model_ovr = 1'b0;
        model_frm = 1'b0;
      end
    end
    bus.mem_addr  = addr;
    bus.mem_wstrb = wstrb;
    bus.mem_wdata = $urandom;
    bus.mem_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.mem_ready !== 1'b1 && n < 8);
    if (bus.mem_ready !== 1'b1) begin
      check({name, "_ready_timeout"}, {31'h0, bus.mem_ready}, 32'h1);
    end
    @(negedge clk);
    rd = bus.mem_rdata;
    @(posedge clk);
    #1;
    check({name, "_ready_once"}, {31'h0, bus.mem_ready}, 32'h0);
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    exp_chk       = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  y;
    logic [7:0]  vec [3];
    checks = 0;
    failures = 0;
    model_ovr = 1'b0;
    model_frm = 1'b0;
    exp_chk = 1'b0;
    exp_rdata = 32'h0;
    exp_name = "none";
    bus.enable = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_instr = 1'b0;
    bus.mem_wstrb = 4'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_addr = 32'h0;
    serial_in = 1'b1;
    resetn = 1'b0;
    idle(3);
    resetn = 1'b1;
    idle(2);

    bus_xfer("rst_status", A_STAT, 4'h0, rd);
    check("rst_status_lit", rd, 32'h0);

    // Single byte
    send_frame(8'hA5, 0);
    bus_xfer("a5_status", A_STAT, 4'h0, rd);
    check("a5_status_lit", rd, 32'h1);
    bus_xfer("a5_data", A_DATA, 4'h0, rd);
    check("a5_data_lit", rd, 32'hA5);
    bus_xfer("a5_status_after", A_STAT, 4'h0, rd);
    check("a5_status_after_lit", rd, 32'h0);

    // Back-to-back frames, then one read past empty
    vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'h3C;
    for (int i = 0; i < 3; i++) send_frame(vec[i], 0);
    for (int i = 0; i < 3; i++) begin
      bus_xfer("b2b_data", A_DATA, 4'h0, rd);
      check("b2b_data_lit", rd, {24'h0, vec[i]});
    end
    bus_xfer("b2b_empty_data", A_DATA, 4'h0, rd);
    check("b2b_empty_lit", rd, 32'h0);
    bus_xfer("b2b_status", A_STAT, 4'h0, rd);
    check("b2b_status_lit", rd, 32'h0);

    // Fill past full: ninth byte is dropped and flags overrun
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0);
    bus_xfer("full_status", A_STAT, 4'h0, rd);
    check("full_status_lit", rd, 32'hB);
    for (int i = 1; i <= 8; i++) begin
      bus_xfer("full_data", A_DATA, 4'h0, rd);
      check("full_data_lit", rd, 32'(i));
    end
    bus_xfer("full_clear", A_STAT, 4'hF, rd);
    bus_xfer("full_status_clr", A_STAT, 4'h0, rd);
    check("full_status_clr_lit", rd, 32'h0);

    // Framing error followed by a clean byte
    send_frame(8'h55, 30);
    idle(4);
    bus_xfer("brk_status", A_STAT, 4'h0, rd);
    check("brk_status_lit", rd, 32'h4);
    send_frame(8'h12, 0);
    bus_xfer("brk_status2", A_STAT, 4'h0, rd);
    check("brk_status2_lit", rd, 32'h5);
    bus_xfer("brk_data", A_DATA, 4'h0, rd);
    check("brk_data_lit", rd, 32'h12);
    bus_xfer("brk_clear", A_STAT, 4'h1, rd);
    bus_xfer("brk_status_clr", A_STAT, 4'h0, rd);
    check("brk_status_clr_lit", rd, 32'h0);

    // Short low glitch while idle
    serial_in = 1'b0;
    idle(3);
    serial_in = 1'b1;
    idle(30);
    bus_xfer("glitch_status", A_STAT, 4'h0, rd);
    check("glitch_status_lit", rd, 32'h0);

    // Reset in the middle of a frame loses both the queued byte and the partial one
    send_frame(8'h99, 0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    resetn = 1'b0;
    serial_in = 1'b1;
    idle(1);
    resetn = 1'b1;
    model_q.delete();
    model_ovr = 1'b0;
    model_frm = 1'b0;
    idle(20);
    send_frame(8'h7E, 0);
    bus_xfer("rst_mid_status", A_STAT, 4'h0, rd);
    check("rst_mid_status_lit", rd, 32'h1);
    bus_xfer("rst_mid_data", A_DATA, 4'h0, rd);
    check("rst_mid_data_lit", rd, 32'h7E);
    bus_xfer("rst_mid_status2", A_STAT, 4'h0, rd);
    check("rst_mid_status2_lit", rd, 32'h0);

    // A pop swept across the window where the next byte is pushed
    for (int w = 90; w <= 105; w++) begin
      y = 8'(w);
      send_frame(8'hA3, 0);
      fork
        send_frame(y, 0);
        begin
          repeat (w) @(posedge clk);
          #1;
          bus_xfer("sweep_pop", A_DATA, 4'h0, rd);
          check("sweep_pop_lit", rd, 32'hA3);
        end
      join
      bus_xfer("sweep_status", A_STAT, 4'h0, rd);
      check("sweep_status_lit", rd, 32'h1);
      bus_xfer("sweep_data", A_DATA, 4'h0, rd);
      check("sweep_data_lit", rd, {24'h0, y});
    end
    bus_xfer("sweep_status_end", A_STAT, 4'h0, rd);
    check("sweep_status_end_lit", rd, 32'h0);

    // Deselected: no acknowledge, no last-read word on the bus, no pop
    send_frame(8'h81, 0);
    bus_xfer("desel_status", A_STAT, 4'h0, rd);
    check("desel_status_lit", rd, 32'h1);
    bus.enable = 1'b0;
    bus.mem_addr = A_DATA;
    bus.mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("desel_ready_driven", {31'h0, bus.mem_ready === 1'b1}, 32'h0);
      check("desel_rdata_driven", {31'h0, bus.mem_rdata === 32'h1}, 32'h0);
    end
    @(posedge clk);
    #1;
    bus.mem_valid = 1'b0;
    bus.enable = 1'b1;
    idle(1);
    bus_xfer("desel_data", A_DATA, 4'h0, rd);
    check("desel_data_lit", rd, 32'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: actual=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
